inst_fetcher: RTL
=================

Name: inst_fetcher

Overview:
- Initiator side of the instruction-fetch interface of mem_ctrl.
- Holds the PC and issues one 32-bit fetch request at a time to mem_ctrl, which serves it byte-by-byte from RAM.
- Buffers returned instructions, tagged with their PC, in a small queue read by the decoder.
- Handles branch/jump redirects, including one that arrives while a fetch is in flight.

Parameters:
IQ_DEPTH, 4, instruction queue entries; power of 2, at least 2
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rdy  in  1  global ready; 0 = pause, all state frozen
inst_IF_req  out  1  fetch request to mem_ctrl (registered)
inst_IF_addr  out  32  fetch address, stable while req=1 (registered)
inst_IF_flag  in  1  one-cycle pulse: inst_IF holds the requested word
inst_IF  in  32  fetched instruction, little-endian assembled
jump_flag  in  1  redirect request, one cycle
jump_pc  in  32  redirect target
iq_ready  in  1  decoder accepts head entry this cycle
iq_valid  out  1  queue non-empty
iq_inst  out  32  head instruction
iq_pc  out  32  PC of head instruction
iq_count  out  clog2(IQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - pc=RESET_PC, state=IDLE.
  - inst_IF_req=0, inst_IF_addr=0.
  - Queue empty: head=tail=0, iq_count=0, iq_valid=0.
  - iq_inst/iq_pc read 0 when empty.
- rdy=0: no register changes. req/addr hold their values. inst_IF_flag, jump_flag and iq_ready are ignored. All rules below apply only on edges with rdy=1.
- At most one request outstanding. mem_ctrl cannot abort, so once req rises, req and addr are held unchanged until inst_IF_flag is seen.
- State IDLE:
  - jump_flag: pc<=jump_pc, flush queue, stay IDLE.
  - Else if iq_count < IQ_DEPTH (before this cycle's pop): req<=1, addr<=pc, go WAIT.
  - Else stay IDLE, req=0.
- State WAIT:
  - flag and jump_flag in the same cycle: drop the word, pc<=jump_pc, flush, req<=0, go IDLE.
  - flag only: push {inst_IF, addr}, pc<=pc+4, req<=0, go IDLE.
  - jump_flag only: pc<=jump_pc, flush, go DISCARD. req/addr are unchanged.
- State DISCARD:
  - req/addr held.
  - jump_flag: pc<=jump_pc (latest wins), flush.
  - flag: drop the word, req<=0, go IDLE. If flag and jump coincide, apply both.
- req is therefore low for at least one cycle between requests.
- Latency: the request is visible one cycle after IDLE is entered with space. A pushed entry is visible at the iq outputs the cycle after the flag edge.
- Queue:
  - Circular buffer; head/tail pointers wrap modulo IQ_DEPTH.
  - iq_valid = (iq_count != 0). iq_inst/iq_pc are combinational from the head entry.
  - Pop when iq_valid & iq_ready & !jump_flag.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Overflow cannot occur: space is checked at issue and the count cannot grow during WAIT. The implementation must assert this in simulation.
  - Flush (jump): count=0, head=tail. Any push or pop that cycle is suppressed.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0. No alignment check; jump_pc is used as given.
- Reset mid-WAIT/DISCARD: req drops asynchronously. mem_ctrl is reset by the same rst, so no stale flag is expected after reset.

Test Plan:
1. Reset with RESET_PC=0, iq_ready=1. Memory model returns addr^32'hA5A50000 five cycles after req. -> Requests at 0,4,8,C. iq_pc 0,4,8,C with iq_inst A5A50000,A5A50004,...; req low exactly one cycle between requests.
2. iq_ready=0 with IQ_DEPTH=4. -> After 4 pushes iq_count=4, req stays 0. Raise iq_ready for one cycle -> count 3, next request addr 0x10.
3. jump_flag with jump_pc=0x100 two cycles after the request for 0x8 rises. -> req/addr=0x8 held until flag, word not pushed, queue empty. Next request addr=0x100, then 0x104.
4. jump_flag coincident with inst_IF_flag for 0xC, jump_pc=0x40. -> Word dropped, no DISCARD. Next request 0x40. A pop asserted that cycle does not occur; count=0.
5. rdy=0 for 3 cycles mid-WAIT, with iq_ready=1 and a spurious jump_flag. -> req/addr, pc, count and head unchanged; fetch completes normally after rdy returns.
6. jump_pc=0xFFFFFFFC, then let it fetch. -> Next request addr 0x0. Assert rst mid-WAIT -> req=0 same cycle; after release the first request is at RESET_PC.

Source files
------------

// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//
// Initiator side of the mem_ctrl instruction-fetch interface. Holds the PC,
// issues one 32-bit fetch at a time, and buffers the returned words, each
// tagged with its PC, in a small circular queue that the decoder drains.
// Branch/jump redirects are accepted at any time. A redirect that lands while
// a fetch is in flight sends the FSM to DISCARD. There it keeps the request
// stable until mem_ctrl answers, because mem_ctrl cannot abort, and then
// drops the stale word.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   rdy               global ready; 0 freezes every register
//   inst_IF_req       registered fetch request to mem_ctrl
//   inst_IF_addr      registered fetch address, stable while req is high
//   inst_IF_flag      one-cycle pulse: inst_IF carries the requested word
//   inst_IF           fetched instruction word
//   jump_flag         one-cycle redirect request
//   jump_pc           redirect target
//   iq_ready          decoder takes the head entry this cycle
//   iq_valid          queue non-empty
//   iq_inst, iq_pc    head entry (zero when the queue is empty)
//   iq_count          queue occupancy
// ---------------------------------------------------------------------------
module inst_fetcher #(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  output logic                        inst_IF_req,
  output logic [31:0]                 inst_IF_addr,
  input  logic                        inst_IF_flag,
  input  logic [31:0]                 inst_IF,
  input  logic                        jump_flag,
  input  logic [31:0]                 jump_pc,
  input  logic                        iq_ready,
  output logic                        iq_valid,
  output logic [31:0]                 iq_inst,
  output logic [31:0]                 iq_pc,
  output logic [$clog2(IQ_DEPTH):0]   iq_count
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic [31:0]     inst_q [IQ_DEPTH];
  logic [31:0]     pc_q   [IQ_DEPTH];

  logic            flush;
  logic            push;
  logic            pop;

  // A redirect always empties the queue and overrides any push or pop in the
  // same cycle. Only a word that comes back in WAIT with no redirect is kept.
  // DISCARD words are stale and are never pushed.
  assign flush = rdy && jump_flag;
  assign push  = rdy && (state == WAIT) && inst_IF_flag && !jump_flag;
  assign pop   = rdy && (count_q != '0) && iq_ready && !jump_flag;

  assign iq_count = count_q;
  assign iq_valid = (count_q != '0);
  assign iq_inst  = (count_q != '0) ? inst_q[head] : 32'h0;
  assign iq_pc    = (count_q != '0) ? pc_q[head]   : 32'h0;

  // Fetch FSM. req and addr are registered here and only change when a fetch
  // is issued or its answer arrives. A redirect during WAIT therefore leaves
  // them alone, and DISCARD waits for the flag before dropping req. Issue is
  // gated on space measured before this cycle's pop. The count cannot grow
  // while a fetch is outstanding, so the pushed word always fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      inst_IF_req  <= 1'b0;
      inst_IF_addr <= 32'h0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (jump_flag) begin
            pc <= jump_pc;
          end else if (count_q < DEPTH_C) begin
            inst_IF_req  <= 1'b1;
            inst_IF_addr <= pc;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (inst_IF_flag && jump_flag) begin
            pc          <= jump_pc;
            inst_IF_req <= 1'b0;
            state       <= IDLE;
          end else if (inst_IF_flag) begin
            pc          <= pc + 32'd4;
            inst_IF_req <= 1'b0;
            state       <= IDLE;
          end else if (jump_flag) begin
            pc    <= jump_pc;
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (jump_flag) begin
            pc <= jump_pc;
          end
          if (inst_IF_flag) begin
            inst_IF_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          inst_IF_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy. A flush moves head onto tail, so the
  // buffer is logically empty without touching the storage. A simultaneous
  // push and pop advances both pointers and leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= tail;
      count_q <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Queue storage has no reset. An entry is only read once the count shows
  // that it was written after the last reset or flush.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[tail] <= inst_IF;
      pc_q[tail]   <= inst_IF_addr;
    end
  end

  // A push into a full queue that is not popped the same cycle would
  // overwrite the head entry. Issue gating is meant to make this impossible.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == DEPTH_C)));

endmodule
